// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: range encoding, measurement
// sequencer states, gate length lookup and the per-range Hz scale factors.
package freq_meter_pkg;

  // Gate range encoding as seen on range_sel / range_out.
  localparam logic [1:0] RANGE_10MS  = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_1S    = 2'd2;

  // Multiplier from edge count to Hz for each range.
  localparam int unsigned SCALE_10MS  = 100;
  localparam int unsigned SCALE_100MS = 10;
  localparam int unsigned SCALE_1S    = 1;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LATCH
  } state_t;

  // Gate length in sys_clk cycles. Range 3 falls into the 1 s case.
  function automatic int unsigned gate_len(input logic [1:0] range,
                                           input int unsigned clk_freq);
    case (range)
      RANGE_10MS:  return clk_freq / 100;
      RANGE_100MS: return clk_freq / 10;
      default:     return clk_freq;
    endcase
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Control/result bundle of the frequency meter sequencer.
//   start, continuous, auto_range, range_sel : requests from the controller side
//   busy, gate                               : live sequencer status
//   freq_cnt, freq_hz, range_out, overflow   : last latched measurement
//   result_valid                             : one-cycle pulse on new results
interface freq_meas_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             continuous;
  logic             auto_range;
  logic [1:0]       range_sel;
  logic             busy;
  logic             gate;
  logic [CNT_W-1:0] freq_cnt;
  logic [CNT_W+6:0] freq_hz;
  logic [1:0]       range_out;
  logic             overflow;
  logic             result_valid;

  modport master (
    output start, continuous, auto_range, range_sel,
    input  busy, gate, freq_cnt, freq_hz, range_out, overflow, result_valid
  );

  modport slave (
    input  start, continuous, auto_range, range_sel,
    output busy, gate, freq_cnt, freq_hz, range_out, overflow, result_valid
  );
endinterface

// File: rtl/sig_edge_sync.sv
// Synchronises an asynchronous square wave into sys_clk and flags its rising
// edges. Detection latency from sig_in to rise is SYNC_STAGES+1 cycles.
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   sig_in  : asynchronous input
//   rise    : high for one cycle per synchronised rising edge
module sig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments make every stage sample the value from
  // before the clock edge; blocking ones would collapse the chain into a wire.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency meter measurement sequencer. Opens a gate of 10 ms / 100 ms / 1 s,
// counts synchronised rising edges of sig_in inside it, then latches the count,
// the scaled Hz value and the range used. Optional continuous re-triggering and
// automatic range selection between measurements.
//   sys_clk, rst_n : clock and asynchronous active-low reset
//   sig_in         : asynchronous square wave under test
//   bus            : control inputs and result outputs (freq_meas_ctrl_if)
module freq_meas_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned     CLK_FREQ    = 100_000_000,
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter longint unsigned LO_TH       = 1000,
  parameter longint unsigned HI_TH       = 64'd2147483648
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  freq_meas_ctrl_if.slave  bus
);

  localparam int unsigned TMR_W = $clog2(CLK_FREQ);
  localparam int unsigned HZ_W  = CNT_W + 7;

  state_t           state_q, state_d;
  logic             rise;
  logic [1:0]       act_range, cur_range, next_range;
  logic [TMR_W-1:0] gate_tmr;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;
  logic [HZ_W-1:0]  cnt_ext, hz_scaled;
  logic             too_high, too_low;

  sig_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .rise    (rise)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start || bus.continuous) state_d = GATE;
      GATE:    if (gate_tmr == '0) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.gate = (state_q == GATE);

  // Range for the gate about to open; manual value 3 clamps to 1 s.
  assign next_range = bus.auto_range ? cur_range
                    : ((bus.range_sel > RANGE_1S) ? RANGE_1S : bus.range_sel);

  // Count-to-Hz scaling by shift-add: x100 = 64+32+4, x10 = 8+2.
  assign cnt_ext = HZ_W'(edge_cnt);
  always_comb begin
    hz_scaled = cnt_ext;
    case (act_range)
      RANGE_10MS:  hz_scaled = (cnt_ext << 6) + (cnt_ext << 5) + (cnt_ext << 2);
      RANGE_100MS: hz_scaled = (cnt_ext << 3) + (cnt_ext << 1);
      default:     hz_scaled = cnt_ext;
    endcase
  end

  assign too_high = ovf || (64'(edge_cnt) > HI_TH);
  assign too_low  = (64'(edge_cnt) < LO_TH);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_range        <= RANGE_10MS;
      cur_range        <= RANGE_10MS;
      gate_tmr         <= '0;
      edge_cnt         <= '0;
      ovf              <= 1'b0;
      bus.freq_cnt     <= '0;
      bus.freq_hz      <= '0;
      bus.range_out    <= RANGE_10MS;
      bus.overflow     <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == GATE) begin
            act_range <= next_range;
            gate_tmr  <= TMR_W'(gate_len(next_range, CLK_FREQ) - 1);
            edge_cnt  <= '0;
            ovf       <= 1'b0;
          end
        end
        GATE: begin
          gate_tmr <= gate_tmr - TMR_W'(1);
          // Saturate rather than wrap; ovf records that an edge was lost.
          if (rise) begin
            if (&edge_cnt) ovf      <= 1'b1;
            else           edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          bus.freq_cnt     <= edge_cnt;
          bus.freq_hz      <= hz_scaled;
          bus.range_out    <= act_range;
          bus.overflow     <= ovf;
          bus.result_valid <= 1'b1;
          if (bus.auto_range) begin
            if (too_high && act_range != RANGE_10MS)
              cur_range <= act_range - 2'd1;
            else if (too_low && act_range != RANGE_1S)
              cur_range <= act_range + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl with CLK_FREQ=1000 (gates of
// 10/100/1000 cycles). Expected counts come from a log of every rising edge
// the bench drives on sig_in, filtered to the window the gate must cover.
module tb_freq_meas_ctrl;
  import freq_meter_pkg::*;

  localparam int unsigned CF   = 1000;
  localparam int unsigned LO   = 4;
  localparam int unsigned HI   = 200;
  localparam int          LAT  = 3;      // sig_in change to counted edge
  localparam int          MAXC = 40000;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic sig_in  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  freq_meas_ctrl_if #(.CNT_W(32)) ifa ();
  freq_meas_ctrl_if #(.CNT_W(8))  ifb ();

  freq_meas_ctrl #(.CLK_FREQ(CF), .CNT_W(32), .SYNC_STAGES(2),
                   .LO_TH(LO), .HI_TH(HI)) dut_a (
    .sys_clk (sys_clk), .rst_n (rst_n), .sig_in (sig_in), .bus (ifa.slave));

  freq_meas_ctrl #(.CLK_FREQ(CF), .CNT_W(8), .SYNC_STAGES(2)) dut_b (
    .sys_clk (sys_clk), .rst_n (rst_n), .sig_in (sig_in), .bus (ifb.slave));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // number of rising clock edges so far
  int sig_period = 0;
  int sig_phase  = 0;
  bit rise_log [MAXC];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Square wave source; logs the cycle in which each rising edge is driven.
  always @(negedge sys_clk) begin
    logic nxt;
    nxt = (sig_period >= 2) ? (((cyc + sig_phase) % sig_period) < (sig_period / 2)) : 1'b0;
    if (nxt && !sig_in && cyc < MAXC) rise_log[cyc] = 1'b1;
    sig_in = nxt;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        busy, gate, ovf, valid;
    logic [1:0]  rng;
    logic [63:0] cnt, hz;
  } obs_t;

  function automatic obs_t sample(input bit use_b);
    obs_t o;
    if (use_b) begin
      o.busy = ifb.busy; o.gate = ifb.gate; o.ovf = ifb.overflow; o.valid = ifb.result_valid;
      o.rng = ifb.range_out; o.cnt = 64'(ifb.freq_cnt); o.hz = 64'(ifb.freq_hz);
    end else begin
      o.busy = ifa.busy; o.gate = ifa.gate; o.ovf = ifa.overflow; o.valid = ifa.result_valid;
      o.rng = ifa.range_out; o.cnt = 64'(ifa.freq_cnt); o.hz = 64'(ifa.freq_hz);
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int glen(input logic [1:0] r);
    return (r == 2'd0) ? int'(CF / 100) : (r == 2'd1) ? int'(CF / 10) : int'(CF);
  endfunction

  function automatic longint unsigned scale_of(input logic [1:0] r);
    return (r == 2'd0) ? SCALE_10MS : (r == 2'd1) ? SCALE_100MS : SCALE_1S;
  endfunction

  // Edges whose detection lands on one of the len counting clock edges after
  // the gate opened at clock edge t.
  function automatic longint unsigned model_count(input int t, input int len);
    longint unsigned n = 0;
    for (int d = t + 1 - LAT; d <= t + len - LAT; d++)
      if (d >= 0 && d < MAXC && rise_log[d]) n++;
    return n;
  endfunction

  task automatic set_start(input bit use_b, input logic v);
    if (use_b) ifb.start = v;
    else       ifa.start = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic check_cleared(input string tag, input bit use_b);
    obs_t o;
    o = sample(use_b);
    check({tag, ".busy"}, o.busy, 0);
    check({tag, ".gate"}, o.gate, 0);
    check({tag, ".cnt"},  o.cnt,  0);
    check({tag, ".hz"},   o.hz,   0);
    check({tag, ".rng"},  o.rng,  0);
    check({tag, ".ovf"},  o.ovf,  0);
    check({tag, ".vld"},  o.valid, 0);
  endtask

  // One manual single-shot measurement; poke >= 0 pulses start again that
  // many cycles into the gate.
  task automatic run_single(input string tag, input bit use_b,
                            input logic [1:0] rsel, input int poke);
    int t, len, gate_n, busy_n, vcyc, xv, xb;
    bit seen;
    logic [1:0] r;
    longint unsigned raw, mx, ec;
    obs_t o;
    r   = (rsel > 2'd2) ? 2'd2 : rsel;
    len = glen(r);
    if (use_b) begin ifb.range_sel = rsel; ifb.auto_range = 0; ifb.continuous = 0; end
    else       begin ifa.range_sel = rsel; ifa.auto_range = 0; ifa.continuous = 0; end
    @(negedge sys_clk);
    set_start(use_b, 1'b1);
    t = cyc + 1;
    @(negedge sys_clk);
    set_start(use_b, 1'b0);
    gate_n = 0; busy_n = 0; vcyc = -1; seen = 0;
    for (int i = 0; i < len + 20 && !seen; i++) begin
      if (i > 0) @(negedge sys_clk);
      if (poke >= 0 && i == poke)     set_start(use_b, 1'b1);
      if (poke >= 0 && i == poke + 1) set_start(use_b, 1'b0);
      o = sample(use_b);
      gate_n += int'(o.gate);
      busy_n += int'(o.busy);
      if (o.valid) begin seen = 1; vcyc = cyc; end
    end
    set_start(use_b, 1'b0);
    raw = model_count(t, len);
    mx  = use_b ? 64'd255 : 64'hFFFF_FFFF;
    ec  = (raw > mx) ? mx : raw;
    o = sample(use_b);
    check({tag, ".seen"},  seen, 1);
    check({tag, ".vtime"}, vcyc, t + len + 1);
    check({tag, ".gate"},  gate_n, len);
    check({tag, ".busy"},  busy_n, len + 1);
    check({tag, ".cnt"},   o.cnt, ec);
    check({tag, ".hz"},    o.hz, ec * scale_of(r));
    check({tag, ".rng"},   o.rng, r);
    check({tag, ".ovf"},   o.ovf, raw > mx);
    xv = 0; xb = 0;
    repeat (20) begin
      @(negedge sys_clk);
      o = sample(use_b);
      xv += int'(o.valid);
      xb += int'(o.busy);
    end
    check({tag, ".xvalid"}, xv, 0);
    check({tag, ".xbusy"},  xb, 0);
  endtask

  // Continuous auto-ranging run on dut_a straight after reset (cur_range 0).
  task automatic run_cont(input string tag, input int nres,
                          input int switch_after, input int new_period);
    int t, len, vcyc, xb;
    bit seen;
    logic [1:0] mr;
    longint unsigned c;
    obs_t o;
    mr = 2'd0;
    ifa.auto_range = 1; ifa.range_sel = 2'd3;
    @(negedge sys_clk);
    ifa.continuous = 1;
    t = cyc + 1;
    for (int k = 0; k < nres; k++) begin
      len = glen(mr);
      seen = 0; vcyc = -1;
      for (int i = 0; i < len + 20 && !seen; i++) begin
        @(negedge sys_clk);
        if (ifa.result_valid) begin seen = 1; vcyc = cyc; end
      end
      if (k == nres - 1) ifa.continuous = 0;
      if (k == switch_after) sig_period = new_period;
      c = model_count(t, len);
      o = sample(0);
      check({tag, ".seen"},  seen, 1);
      check({tag, ".vtime"}, vcyc, t + len + 1);
      check({tag, ".rng"},   o.rng, mr);
      check({tag, ".cnt"},   o.cnt, c);
      check({tag, ".hz"},    o.hz, c * scale_of(mr));
      if (c > HI && mr > 0)      mr = mr - 2'd1;
      else if (c < LO && mr < 2) mr = mr + 2'd1;
      t = t + len + 2;
    end
    xb = 0;
    repeat (10) begin
      @(negedge sys_clk);
      xb += int'(ifa.busy);
    end
    check({tag, ".stop"}, xb, 0);
    ifa.auto_range = 0;
  endtask

  initial begin
    int vcnt, bcnt;
    ifa.start = 0; ifa.continuous = 0; ifa.auto_range = 0; ifa.range_sel = 0;
    ifb.start = 0; ifb.continuous = 0; ifb.auto_range = 0; ifb.range_sel = 0;

    do_reset();
    check_cleared("rst_a", 0);
    check_cleared("rst_b", 1);

    // Single shot, 10 ms, sig_in toggling every cycle.
    sig_period = 2;
    run_single("r0", 0, 2'd0, -1);

    // 1 s gate with a stray start pulse during the gate.
    run_single("r2", 0, 2'd2, 300);

    // Reset at gate cycle 500 of a 1 s measurement.
    ifa.range_sel = 2'd2;
    @(negedge sys_clk);
    ifa.start = 1;
    @(negedge sys_clk);
    ifa.start = 0;
    repeat (499) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check_cleared("midrst", 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    vcnt = 0; bcnt = 0;
    repeat (1100) begin
      @(negedge sys_clk);
      vcnt += int'(ifa.result_valid);
      bcnt += int'(ifa.busy);
    end
    check("midrst.novalid", vcnt, 0);
    check("midrst.idle", bcnt, 0);
    run_single("postrst", 0, 2'd2, -1);

    // Saturation with an 8-bit counter.
    run_single("ovf", 1, 2'd2, -1);

    // Auto-range up: slow input pushes 10 ms to 100 ms, then stays.
    do_reset();
    sig_period = 20;
    sig_phase  = $urandom_range(0, 19);
    run_cont("aup", 4, -1, 0);

    // Auto-range down: climb to 1 s on a slow input, then switch to a fast one.
    do_reset();
    sig_period = 40;
    sig_phase  = $urandom_range(0, 39);
    run_cont("adn", 5, 1, 2);

    // Randomised manual measurements.
    for (int k = 0; k < 10; k++) begin
      sig_period = $urandom_range(2, 25);
      sig_phase  = $urandom_range(0, 31);
      run_single("rnd_a", 0, 2'($urandom_range(0, 3)), -1);
    end
    for (int k = 0; k < 3; k++) begin
      sig_period = $urandom_range(2, 25);
      sig_phase  = $urandom_range(0, 31);
      run_single("rnd_b", 1, 2'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer for the board's frequency meter, driven by the 100 MHz system clock. Synchronises the external test square wave and opens timed gate windows of 10 ms, 100 ms or 1 s. Counts input rising edges within each window, then latches the count and a scaled Hz value. Supports single-shot or continuous operation, and optionally auto-ranges the gate between measurements; results feed the LED/display logic.

Parameters:
CLK_FREQ, 100_000_000, sys_clk cycles per second; gate lengths are CLK_FREQ/100, CLK_FREQ/10 and CLK_FREQ cycles for ranges 0/1/2.
CNT_W, 32, edge counter and freq_cnt width.
SYNC_STAGES, 2, synchroniser depth for sig_in (>=2).
LO_TH, 1000, auto-range threshold: count below this selects a longer gate.
HI_TH, 2**31, auto-range threshold: count above this, or overflow, selects a shorter gate.

Ports:
sys_clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
sig_in  in  1  asynchronous test square wave.
start  in  1  one-cycle request for a single measurement; ignored while busy.
continuous  in  1  1 = restart automatically after every measurement.
auto_range  in  1  1 = controller selects the range; 0 = range_sel is used.
range_sel  in  2  manual range: 0 = 10 ms, 1 = 100 ms, 2 = 1 s; 3 is treated as 2.
busy  out  1  high from gate open through the latch cycle.
gate  out  1  high while edges are being counted.
freq_cnt  out  CNT_W  edge count from the last completed gate.
freq_hz  out  CNT_W+7  freq_cnt x {100, 10, 1} for ranges {0, 1, 2}.
range_out  out  2  range used for the latched result.
overflow  out  1  the latched count saturated.
result_valid  out  1  one-cycle pulse when new results are latched.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; cur_range = 0; synchroniser and edge-detect flops = 0.
- Edge detect: sig_in passes through a SYNC_STAGES flop chain, then one previous-value flop. A rising edge is sync & ~prev, giving a detection latency of SYNC_STAGES+1 cycles.
- IDLE state, busy = 0:
  - Leave IDLE when start=1 or continuous=1.
  - On leaving, sample the range: auto_range ? cur_range : min(range_sel, 2). This becomes act_range.
  - Load gate_tmr = gate_len(act_range) - 1, clear edge_cnt and ovf, and go to GATE.
- GATE state, gate = 1, busy = 1:
  - Each cycle a detected rising edge increments edge_cnt.
  - At all-ones, edge_cnt holds and ovf is set.
  - gate_tmr decrements each cycle. When gate_tmr == 0, an edge in that same cycle is still counted, and the FSM moves to LATCH.
  - The gate is therefore exactly gate_len cycles wide.
- LATCH state, busy = 1, gate = 0, lasts one cycle:
  - Registered on exit: freq_cnt <= edge_cnt, overflow <= ovf, range_out <= act_range, and freq_hz <= edge_cnt scaled by shift-add (x100 = <<6 + <<5 + <<2; x10 = <<3 + <<1).
  - result_valid = 1 in the cycle after LATCH, for exactly one cycle.
  - Auto-range update, only when auto_range = 1: if (ovf or edge_cnt > HI_TH) and act_range > 0, cur_range <= act_range - 1. Else if edge_cnt < LO_TH and act_range < 2, cur_range <= act_range + 1. Otherwise cur_range is unchanged.
  - Next state is IDLE.
- Continuous mode: the period from one gate open to the next is gate_len + 2 cycles, with no edges counted outside the gate.
- start while busy is dropped and not queued. range_sel and auto_range changes during GATE take effect at the next gate open.
- Outputs hold their last values until the next LATCH.
- rst_n asserted mid-gate aborts the measurement, clears all outputs and produces no result_valid.

Decomposition:
- Package freq_meter_pkg holds:
  - the range encoding constants (RANGE_10MS/100MS/1S);
  - the FSM state enum (IDLE, GATE, LATCH);
  - the gate_len(range, CLK_FREQ) function;
  - the scale-factor constants.
- Sub-module sig_edge_sync(sys_clk, rst_n, sig_in, rise) holds the synchroniser and edge detect, and is reused by the period-measurement block.

Test Plan:
All scenarios use CLK_FREQ=1000, giving gates of 10/100/1000 cycles. Fixed phase means the counts are exact.
1. Reset mid-gate: manual range 2, start, assert rst_n for 1 cycle at gate cycle 500 -> all outputs 0, no result_valid, busy=0; a new start gives a normal result.
2. Single shot: manual range 0, sig_in toggling every cycle, one start pulse -> gate high for 10 cycles, freq_cnt=5, freq_hz=500, range_out=0, result_valid one pulse, busy=0 afterwards.
3. Range 2 with same stimulus -> freq_cnt=500, freq_hz=500, range_out=2; a start pulse during GATE is ignored, so exactly one result_valid.
4. Overflow: CNT_W=8, range 2, sig_in toggling -> freq_cnt=255, overflow=1, freq_hz=255.
5. Auto-range up: auto_range=1, continuous=1, LO_TH=4, sig_in period 20 cycles -> the first result has range_out=0 and count<=1; the next has range_out=1 and count=5, and the range stays 1.
6. Auto-range down: HI_TH=200, cur_range reaches 2, sig_in toggling gives count 500>HI_TH -> next range_out=1 with count 50; range then stays at 1 while count is between LO_TH and HI_TH.
